// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive-frame path:
// FSM states, EOF status codes, framing bytes, CRC-32 parameters and length limits.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_DATA      = 3'd3,
        ST_DROP      = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        STAT_OK   = 2'd0,
        STAT_CRC  = 2'd1,
        STAT_LEN  = 2'd2,
        STAT_ADDR = 2'd3
    } rx_status_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Residue is expressed MSB-first; the reflected CRC register must be bit-reversed before comparing.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    localparam int          LEN_W         = 11;
    localparam logic [LEN_W-1:0] MIN_LEN  = 11'd64;
    localparam logic [LEN_W-1:0] MAX_LEN  = 11'd1518;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Byte 0 of a MAC address is its most significant byte on the wire.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            default: b = mac[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_rx_frame_crc32_d8.sv
// Byte-wide CRC-32 next-state function, reflected polynomial, data consumed LSB first.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_frame.sv
// Ethernet receive framer: strips preamble/SFD, forwards dest..payload through a
// 4-byte delay line (dropping FCS), and reports CRC/length/address status at end of frame.
module eth_rx_frame
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter logic        PROMISC  = 1'b0
) (
    input  logic        RGMII_RX_CLK,
    input  logic        RESET_N,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_DV,
    output logic [7:0]  M_DATA,
    output logic        M_VALID,
    output logic        M_SOF,
    output logic        M_EOF,
    output logic [1:0]  M_STATUS,
    output logic [15:0] FRAME_CNT,
    output logic [15:0] ERR_CNT,
    output logic [15:0] DROP_CNT
);

    rx_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic [3:0][7:0]  dl_q, dl_d;
    logic             from_data_q, from_data_d;
    logic             da_ok_q, da_ok_d;
    logic             bc_ok_q, bc_ok_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_sof_q, m_sof_d;
    logic             m_eof_q, m_eof_d;
    rx_status_e       m_status_q, m_status_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             data_take;
    rx_status_e       frame_status;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (RX_DATA),
        .crc_out (crc_next)
    );

    // FCS-stripping delay line: tap 3 holds the byte sampled four bytes ago.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign dl_d[gi] = data_take ? RX_DATA : dl_q[gi];
            end else begin : g_tap
                assign dl_d[gi] = data_take ? dl_q[gi-1] : dl_q[gi];
            end
        end
    endgenerate

    always_comb begin
        frame_status = STAT_OK;
        if (len_q < MIN_LEN || len_q > MAX_LEN) begin
            frame_status = STAT_LEN;
        end else if (bitrev32(crc_q) != CRC_RESIDUE) begin
            frame_status = STAT_CRC;
        end else if (!da_ok_q && !bc_ok_q && !PROMISC) begin
            frame_status = STAT_ADDR;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        crc_d       = crc_q;
        from_data_d = from_data_q;
        da_ok_d     = da_ok_q;
        bc_ok_d     = bc_ok_q;
        m_data_d    = m_data_q;
        m_valid_d   = 1'b0;
        m_sof_d     = 1'b0;
        m_eof_d     = 1'b0;
        m_status_d  = m_status_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        data_take   = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (!RX_DV) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (RX_DV) begin
                    if (RX_DATA == PREAMBLE_BYTE) begin
                        state_d = ST_PREAMBLE;
                    end else begin
                        state_d     = ST_DROP;
                        from_data_d = 1'b0;
                        drop_cnt_d  = drop_cnt_q + 16'd1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!RX_DV) begin
                    state_d = ST_IDLE;
                end else if (RX_DATA == SFD_BYTE) begin
                    state_d = ST_DATA;
                    len_d   = '0;
                    crc_d   = CRC_INIT;
                    da_ok_d = 1'b1;
                    bc_ok_d = 1'b1;
                end else if (RX_DATA != PREAMBLE_BYTE) begin
                    state_d     = ST_DROP;
                    from_data_d = 1'b0;
                    drop_cnt_d  = drop_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (!RX_DV) begin
                    state_d    = ST_IDLE;
                    m_eof_d    = 1'b1;
                    m_status_d = frame_status;
                    if (frame_status == STAT_OK) frame_cnt_d = frame_cnt_q + 16'd1;
                    else                         err_cnt_d   = err_cnt_q + 16'd1;
                end else if (len_q == MAX_LEN) begin
                    state_d     = ST_DROP;
                    from_data_d = 1'b1;
                end else begin
                    data_take = 1'b1;
                    len_d     = len_q + 11'd1;
                    crc_d     = crc_next;
                    if (len_q < 11'd6) begin
                        da_ok_d = da_ok_q && (RX_DATA == mac_byte(MAC_ADDR, len_q[2:0]));
                        bc_ok_d = bc_ok_q && (RX_DATA == 8'hFF);
                    end
                    if (len_q >= 11'd4) begin
                        m_valid_d = 1'b1;
                        m_data_d  = dl_q[3];
                        m_sof_d   = (len_q == 11'd4);
                    end
                end
            end
            ST_DROP: begin
                if (!RX_DV) begin
                    state_d = ST_IDLE;
                    if (from_data_q) begin
                        m_eof_d    = 1'b1;
                        m_status_d = STAT_LEN;
                        err_cnt_d  = err_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge RGMII_RX_CLK) begin
        if (!RESET_N) begin
            state_q     <= ST_WAIT_IDLE;
            len_q       <= '0;
            crc_q       <= CRC_INIT;
            dl_q        <= '0;
            from_data_q <= 1'b0;
            da_ok_q     <= 1'b0;
            bc_ok_q     <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            m_status_q  <= STAT_OK;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            dl_q        <= dl_d;
            from_data_q <= from_data_d;
            da_ok_q     <= da_ok_d;
            bc_ok_q     <= bc_ok_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_sof_q     <= m_sof_d;
            m_eof_q     <= m_eof_d;
            m_status_q  <= m_status_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign M_DATA    = m_data_q;
    assign M_VALID   = m_valid_q;
    assign M_SOF     = m_sof_q;
    assign M_EOF     = m_eof_q;
    assign M_STATUS  = m_status_q;
    assign FRAME_CNT = frame_cnt_q;
    assign ERR_CNT   = err_cnt_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame.sv
// Scoreboard bench for eth_rx_frame: expected beats and EOF statuses are queued as
// bytes are driven and checked by a monitor on the falling clock edge.
module tb_eth_rx_frame;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_dv = 1'b0;

    logic [7:0]  m_data, p_m_data;
    logic        m_valid, p_m_valid;
    logic        m_sof, p_m_sof;
    logic        m_eof, p_m_eof;
    logic [1:0]  m_status, p_m_status;
    logic [15:0] frame_cnt, err_cnt, drop_cnt;
    logic [15:0] p_frame_cnt, p_err_cnt, p_drop_cnt;

    typedef struct {
        logic [7:0] data;
        logic       sof;
    } beat_t;

    beat_t      q_beat[$];
    logic [1:0] q_stat[$];
    logic [1:0] q_stat_p[$];
    logic [7:0] fr[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_frame = 0, exp_err = 0, exp_drop = 0;
    int exp_p_frame = 0, exp_p_err = 0;

    beat_t      mon_b;
    logic [1:0] mon_s;

    always #4 clk = ~clk;

    eth_rx_frame #(.MAC_ADDR(MAC), .PROMISC(1'b0)) u_dut (
        .RGMII_RX_CLK (clk),
        .RESET_N      (rst_n),
        .RX_DATA      (rx_data),
        .RX_DV        (rx_dv),
        .M_DATA       (m_data),
        .M_VALID      (m_valid),
        .M_SOF        (m_sof),
        .M_EOF        (m_eof),
        .M_STATUS     (m_status),
        .FRAME_CNT    (frame_cnt),
        .ERR_CNT      (err_cnt),
        .DROP_CNT     (drop_cnt)
    );

    eth_rx_frame #(.MAC_ADDR(MAC), .PROMISC(1'b1)) u_dut_p (
        .RGMII_RX_CLK (clk),
        .RESET_N      (rst_n),
        .RX_DATA      (rx_data),
        .RX_DV        (rx_dv),
        .M_DATA       (p_m_data),
        .M_VALID      (p_m_valid),
        .M_SOF        (p_m_sof),
        .M_EOF        (p_m_eof),
        .M_STATUS     (p_m_status),
        .FRAME_CNT    (p_frame_cnt),
        .ERR_CNT      (p_err_cnt),
        .DROP_CNT     (p_drop_cnt)
    );

    // Scoreboard monitor: every beat and EOF must match the head of its queue.
    always @(negedge clk) begin
        if (m_valid) begin
            tests_run++;
            if (q_beat.size() == 0) begin
                tests_failed++;
                $display("FAIL beat_unexpected: got data=%02h sof=%0b, none expected", m_data, m_sof);
            end else begin
                mon_b = q_beat.pop_front();
                if (m_data !== mon_b.data || m_sof !== mon_b.sof) begin
                    tests_failed++;
                    $display("FAIL beat: got data=%02h sof=%0b, want data=%02h sof=%0b",
                             m_data, m_sof, mon_b.data, mon_b.sof);
                end
            end
        end
        if (m_eof) begin
            tests_run++;
            if (q_stat.size() == 0) begin
                tests_failed++;
                $display("FAIL eof_unexpected: got status=%0d, none expected", m_status);
            end else begin
                mon_s = q_stat.pop_front();
                if (mon_s == 2'd0) exp_frame++;
                else               exp_err++;
                if (m_status !== mon_s || m_valid !== 1'b0 ||
                    frame_cnt !== 16'(exp_frame) || err_cnt !== 16'(exp_err)) begin
                    tests_failed++;
                    $display("FAIL eof: got status=%0d valid=%0b frames=%0d errs=%0d, want status=%0d valid=0 frames=%0d errs=%0d",
                             m_status, m_valid, frame_cnt, err_cnt, mon_s, exp_frame, exp_err);
                end
            end
        end
        if (p_m_eof) begin
            tests_run++;
            if (q_stat_p.size() == 0) begin
                tests_failed++;
                $display("FAIL eof_promisc_unexpected: got status=%0d, none expected", p_m_status);
            end else begin
                mon_s = q_stat_p.pop_front();
                if (mon_s == 2'd0) exp_p_frame++;
                else               exp_p_err++;
                if (p_m_status !== mon_s || p_frame_cnt !== 16'(exp_p_frame) || p_err_cnt !== 16'(exp_p_err)) begin
                    tests_failed++;
                    $display("FAIL eof_promisc: got status=%0d frames=%0d errs=%0d, want status=%0d frames=%0d errs=%0d",
                             p_m_status, p_frame_cnt, p_err_cnt, mon_s, exp_p_frame, exp_p_err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic dv, input logic [7:0] d);
        @(negedge clk);
        rx_dv   = dv;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input int len);
        logic [31:0] fcs;
        fr.delete();
        for (int i = 0; i < len - 4; i++) begin
            if (i < 6)        fr.push_back(dst[47-8*i -: 8]);
            else if (i < 12)  fr.push_back(8'(8'hA0 + i));
            else if (i == 12) fr.push_back(8'h08);
            else if (i == 13) fr.push_back(8'h00);
            else              fr.push_back(8'(i * 7 + 3));
        end
        fcs = ~crc_of(len - 4);
        fr.push_back(fcs[7:0]);
        fr.push_back(fcs[15:8]);
        fr.push_back(fcs[23:16]);
        fr.push_back(fcs[31:24]);
    endtask

    function automatic logic [1:0] model_status(input logic promisc);
        int          len;
        logic [31:0] calc, rx_fcs;
        logic [47:0] dst;
        len = fr.size();
        if (len < 64 || len > 1518) return 2'd2;
        calc   = ~crc_of(len - 4);
        rx_fcs = {fr[len-1], fr[len-2], fr[len-3], fr[len-4]};
        if (calc != rx_fcs) return 2'd1;
        dst = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
        if (dst != MAC && dst != BCAST && !promisc) return 2'd3;
        return 2'd0;
    endfunction

    task automatic send_frame(input int gap);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int n = 0; n < fr.size(); n++) begin
            if (n >= 4 && n < 1518) q_beat.push_back('{data: fr[n-4], sof: (n == 4)});
            drive(1'b1, fr[n]);
        end
        q_stat.push_back(model_status(1'b0));
        q_stat_p.push_back(model_status(1'b1));
        idle(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({m_data, m_valid, m_sof, m_eof, m_status, frame_cnt, err_cnt, drop_cnt} !== 62'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got data=%02h v=%0b sof=%0b eof=%0b st=%0d f=%0d e=%0d d=%0d, want all 0",
                     m_data, m_valid, m_sof, m_eof, m_status, frame_cnt, err_cnt, drop_cnt);
        end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good_frame();
        build_frame(MAC, 64);
        send_frame(6);
        tests_run++;
        if (q_beat.size() != 0 || q_stat.size() != 0 || frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL good_frame: got beats_left=%0d eofs_left=%0d frames=%0d, want 0 0 1",
                     q_beat.size(), q_stat.size(), frame_cnt);
        end
    endtask

    task automatic test_crc_error();
        build_frame(MAC, 64);
        fr[34] = fr[34] ^ 8'h01;
        send_frame(6);
        tests_run++;
        if (q_beat.size() != 0 || q_stat.size() != 0 || err_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL crc_error: got beats_left=%0d eofs_left=%0d errs=%0d, want 0 0 1",
                     q_beat.size(), q_stat.size(), err_cnt);
        end
    endtask

    task automatic test_address();
        build_frame(BCAST, 64);
        send_frame(6);
        build_frame(OTHER, 80);
        send_frame(6);
        tests_run++;
        if (q_stat.size() != 0 || q_stat_p.size() != 0 || frame_cnt !== 16'd2 || err_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL address: got eofs_left=%0d/%0d frames=%0d errs=%0d, want 0/0 2 2",
                     q_stat.size(), q_stat_p.size(), frame_cnt, err_cnt);
        end
    endtask

    task automatic test_length();
        build_frame(MAC, 20);
        send_frame(6);
        build_frame(MAC, 1600);
        send_frame(6);
        tests_run++;
        if (q_beat.size() != 0 || q_stat.size() != 0 || err_cnt !== 16'd4) begin
            tests_failed++;
            $display("FAIL length: got beats_left=%0d eofs_left=%0d errs=%0d, want 0 0 4",
                     q_beat.size(), q_stat.size(), err_cnt);
        end
    endtask

    task automatic test_bad_preamble();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h12);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h30 + i));
        idle(4);
        exp_drop++;
        tests_run++;
        if (drop_cnt !== 16'(exp_drop) || p_drop_cnt !== 16'(exp_drop) || frame_cnt !== 16'd2 || err_cnt !== 16'd4) begin
            tests_failed++;
            $display("FAIL bad_preamble: got drops=%0d/%0d frames=%0d errs=%0d, want drops=%0d frames=2 errs=4",
                     drop_cnt, p_drop_cnt, frame_cnt, err_cnt, exp_drop);
        end
    endtask

    task automatic test_back_to_back();
        build_frame(MAC, 64);
        send_frame(1);
        build_frame(BCAST, 70);
        send_frame(6);
        tests_run++;
        if (q_beat.size() != 0 || q_stat.size() != 0 || frame_cnt !== 16'd4) begin
            tests_failed++;
            $display("FAIL back_to_back: got beats_left=%0d eofs_left=%0d frames=%0d, want 0 0 4",
                     q_beat.size(), q_stat.size(), frame_cnt);
        end
    endtask

    task automatic test_mid_frame_reset();
        build_frame(MAC, 64);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int n = 0; n < 30; n++) begin
            if (n >= 4) q_beat.push_back('{data: fr[n-4], sof: (n == 4)});
            drive(1'b1, fr[n]);
        end
        @(negedge clk);
        rst_n   = 1'b0;
        rx_dv   = 1'b1;
        rx_data = fr[30];
        exp_frame = 0; exp_err = 0; exp_drop = 0; exp_p_frame = 0; exp_p_err = 0;
        for (int k = 31; k < 34; k++) begin
            @(negedge clk);
            tests_run++;
            if ({m_valid, m_sof, m_eof, m_data, m_status, frame_cnt, err_cnt, drop_cnt} !== 62'd0) begin
                tests_failed++;
                $display("FAIL mid_reset_outputs: got v=%0b sof=%0b eof=%0b data=%02h st=%0d f=%0d e=%0d d=%0d, want all 0",
                         m_valid, m_sof, m_eof, m_data, m_status, frame_cnt, err_cnt, drop_cnt);
            end
            rx_data = fr[k];
            if (k == 33) rst_n = 1'b1;
        end
        for (int n = 34; n < 64; n++) drive(1'b1, fr[n]);
        idle(4);
        tests_run++;
        if (q_beat.size() != 0 || q_stat.size() != 0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_discard: got beats_left=%0d eofs_left=%0d frames=%0d errs=%0d, want 0 0 0 0",
                     q_beat.size(), q_stat.size(), frame_cnt, err_cnt);
        end
        build_frame(MAC, 64);
        send_frame(6);
        tests_run++;
        if (q_stat.size() != 0 || frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_recover: got eofs_left=%0d frames=%0d errs=%0d, want 0 1 0",
                     q_stat.size(), frame_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_address();
        test_length();
        test_bad_preamble();
        test_back_to_back();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
